// File: rtl/relm_float_pkg.sv
// Purpose: shared field layout, constants and stage-1 record for the float pack pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package relm_float_pkg;

    // Field positions of the packed IEEE single and of the B operand flags.
    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int INF_BIT  = 22;
    localparam int ZERO_BIT = 21;
    localparam int FRAC_HI  = 22;
    localparam int FRAC_LO  = 0;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [22:0] QNAN_FRAC = 23'h400000;

    // Normalised operand held between stage 1 and stage 2.
    // exp is a 10-bit two's-complement exponent (may go negative or past 255).
    typedef struct packed {
        logic [30:0] man;
        logic [9:0]  exp;
        logic        sign;
        logic        inf;
        logic        zero;
        logic        zflag;
    } s1_t;

endpackage

// File: rtl/relm_float_lzc.sv
// Purpose: 31-bit leading-zero counter with all-zero flag.
// Latency: combinational.
// Backpressure: none.
module relm_float_lzc (
    input  logic [30:0] din,
    output logic [4:0]  cnt,
    output logic        all_zero
);

    // Scan upward so the highest set bit determines the count; 31 when empty.
    always_comb begin
        cnt      = 5'd31;
        all_zero = 1'b1;
        for (int i = 0; i < 31; i++) begin
            if (din[i]) begin
                cnt      = 5'(30 - i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/relm_float_pack.sv
// Purpose: normalise, round-to-nearest-even and pack a raw float result into IEEE single.
// Latency: 2 cycles (normalise register, then round/pack output register); 1 word/cycle.
// Backpressure: elastic; in_ready = !s1_vld | s2_adv, output held stable while out_ready is low.
module relm_float_pack
    import relm_float_pkg::*;
#(
    parameter int WD = 32,
    parameter int WT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WD-1:0] in_a,
    input  logic [WD-1:0] in_b,
    input  logic [WT-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WD-1:0] out_data,
    output logic [WT-1:0] out_tag
);

    logic          s1_vld;
    logic          s2_vld;
    logic          s2_adv;
    s1_t           s1_q;
    s1_t           s1_nxt;
    logic [WT-1:0] s1_tag;

    logic [4:0]    lz;
    logic          lz_zero;
    logic [31:0]   shifted;

    logic [22:0]   frac;
    logic          guard;
    logic          sticky;
    logic          rnd;
    logic [23:0]   frac_sum;
    logic [9:0]    e_r;
    logic [31:0]   packed_word;

    // Low B bits carry no meaning for this stage.
    logic          unused_b;
    assign unused_b = ^in_b[20:0];

    assign s2_adv    = !s2_vld || out_ready;
    assign in_ready  = !s1_vld || s2_adv;
    assign out_valid = s2_vld;

    relm_float_lzc u_lzc (
        .din      (in_a[30:0]),
        .cnt      (lz),
        .all_zero (lz_zero)
    );

    // Stage 1: bring the leading one to bit 30, tracking the exponent shift.
    always_comb begin
        s1_nxt       = '0;
        shifted      = in_a << lz;
        s1_nxt.sign  = in_b[SIGN_BIT];
        s1_nxt.inf   = in_b[INF_BIT];
        s1_nxt.zero  = in_b[ZERO_BIT];
        s1_nxt.zflag = lz_zero && !in_a[31];
        if (in_a[31]) begin
            // Right shift by one; the dropped bit folds into the sticky position.
            s1_nxt.man = {in_a[31:2], in_a[1] | in_a[0]};
            s1_nxt.exp = {2'b00, in_b[EXP_HI:EXP_LO]} + 10'd1;
        end else begin
            s1_nxt.man = shifted[30:0];
            s1_nxt.exp = {2'b00, in_b[EXP_HI:EXP_LO]} - {5'b00000, lz};
        end
    end

    // Stage 2: round to nearest-even and select the packed result by priority.
    always_comb begin
        frac     = s1_q.man[29:7];
        guard    = s1_q.man[6];
        sticky   = |s1_q.man[5:0];
        rnd      = guard && (sticky || frac[0]);
        frac_sum = {1'b0, frac} + {23'd0, rnd};
        // A carry out leaves frac_sum[22:0] at zero, which is the renormalised fraction.
        e_r      = s1_q.exp + {9'd0, frac_sum[23]};

        if (s1_q.inf && s1_q.zero) begin
            packed_word = {s1_q.sign, 8'hFF, QNAN_FRAC};
        end else if (s1_q.inf) begin
            packed_word = {s1_q.sign, 8'hFF, 23'd0};
        end else if (s1_q.zero) begin
            packed_word = {s1_q.sign, 31'd0};
        end else if (s1_q.zflag) begin
            packed_word = 32'h0000_0000;
        end else if ($signed(e_r) >= EXP_MAX) begin
            packed_word = {s1_q.sign, 8'hFF, 23'd0};
        end else if ($signed(e_r) <= 0) begin
            packed_word = {s1_q.sign, 31'd0};
        end else begin
            packed_word = {s1_q.sign, e_r[7:0], frac_sum[FRAC_HI:FRAC_LO]};
        end
    end

    // Pipeline registers with valid/ready advance; reset empties both stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld   <= 1'b0;
            s2_vld   <= 1'b0;
            s1_q     <= '0;
            s1_tag   <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            if (s2_adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    out_data <= packed_word;
                    out_tag  <= s1_tag;
                end
            end
            if (in_ready) begin
                s1_vld <= in_valid;
                if (in_valid) begin
                    s1_q   <= s1_nxt;
                    s1_tag <= in_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_relm_float_pack.sv
module tb_relm_float_pack;

    localparam int WD = 32;
    localparam int WT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [WD-1:0] in_a;
    logic [WD-1:0] in_b;
    logic [WT-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [WD-1:0] out_data;
    logic [WT-1:0] out_tag;

    int total = 0;
    int bad   = 0;

    logic [31:0]   r_data;
    logic [WT-1:0] r_tag;
    int            r_lat;
    bit            r_ok;

    always #5 clk = ~clk;

    relm_float_pack #(.WD(WD), .WT(WT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    // Reference: value = a * 2^(exp-127-30); round the integer a to 24 significant
    // bits nearest-even, then apply the special-case priority.
    function automatic logic [31:0] ref_pack(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ex;
        int     p;
        int     sh;
        int     eb;
        longint q;
        longint rem;
        longint half;
        s  = b[31];
        ex = int'(b[30:23]);
        if (b[22] && b[21]) return {s, 8'hFF, 23'h400000};
        if (b[22]) return {s, 8'hFF, 23'h0};
        if (b[21]) return {s, 31'd0};
        if (a == 32'd0) return 32'h0;
        p = 0;
        for (int i = 0; i < 32; i++) if (a[i]) p = i;
        eb = ex + p - 30;
        if (p > 23) begin
            sh   = p - 23;
            q    = longint'(a) >> sh;
            rem  = longint'(a) - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q  = longint'(1) << 23;
                eb = eb + 1;
            end
        end else begin
            q = longint'(a) << (23 - p);
        end
        if (eb >= 255) return {s, 8'hFF, 23'h0};
        if (eb <= 0) return {s, 31'd0};
        return {s, 8'(eb), q[22:0]};
    endfunction

    // Sends one word with out_ready high and captures the first output (no checking here).
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [WT-1:0] t);
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_tag    = t;
        out_ready = 1'b1;
        @(posedge clk);
        r_ok  = 1'b0;
        r_lat = 0;
        for (int c = 1; c <= 20 && !r_ok; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) begin
                r_ok   = 1'b1;
                r_lat  = c;
                r_data = out_data;
                r_tag  = out_tag;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++;
        if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++;
        if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    endtask

    localparam logic [31:0] DIR_A [12] = '{
        32'h80000000, 32'h00000080, 32'h00000000, 32'h40000040,
        32'h400000C0, 32'h7FFFFFC0, 32'h80000000, 32'h20000000,
        32'h40000000, 32'h12345678, 32'h40000000, 32'h40000000 };
    localparam logic [31:0] DIR_B [12] = '{
        32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
        32'h3F800000, 32'h3F800000, 32'h7F000000, 32'h80800000,
        32'h00600000, 32'h80400000, 32'hBFA00000, 32'h3FE00000 };
    localparam logic [31:0] DIR_X [12] = '{
        32'h40000000, 32'h34000000, 32'h00000000, 32'h3F800000,
        32'h3F800002, 32'h40000000, 32'h7F800000, 32'h80000000,
        32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h7FC00000 };

    task automatic test_directed();
        for (int i = 0; i < 12; i++) begin
            run_one(DIR_A[i], DIR_B[i], 4'(i + 3));
            total++;
            if (!r_ok || r_lat != 2) begin
                bad++;
                $display("FAIL dir_latency[%0d] got_valid=%b got_lat=%0d want=2", i, r_ok, r_lat);
            end
            total++;
            if (r_data !== DIR_X[i]) begin
                bad++;
                $display("FAIL dir_data[%0d] a=%h b=%h got=%h want=%h", i, DIR_A[i], DIR_B[i], r_data, DIR_X[i]);
            end
            total++;
            if (r_tag !== 4'(i + 3)) begin
                bad++;
                $display("FAIL dir_tag[%0d] got=%h want=%h", i, r_tag, 4'(i + 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]   va [4];
        logic [31:0]   vb [4];
        logic [31:0]   held_d;
        logic [WT-1:0] held_t;
        bit            held;
        int            sent;
        int            got;
        va = '{32'h40000000, 32'h60000000, 32'h80000000, 32'h00001234};
        vb = '{32'h3F800000, 32'h40000000, 32'hC1000000, 32'h3F800000};
        sent = 0;
        got  = 0;
        held = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            in_valid  = (sent < 4);
            in_a      = va[sent % 4];
            in_b      = vb[sent % 4];
            in_tag    = 4'(sent + 1);
            #1;
            if (cyc == 2) begin
                total++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    bad++;
                    $display("FAIL b2b_stall_accept got_in_ready=%b got_sent=%0d want_in_ready=0 want_sent=2", in_ready, sent);
                end
            end
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t) begin
                    bad++;
                    $display("FAIL b2b_hold got=%b/%h/%h want=1/%h/%h", out_valid, out_data, out_tag, held_d, held_t);
                end
            end
            held   = out_valid && !out_ready;
            held_d = out_data;
            held_t = out_tag;
            if (out_valid && out_ready) begin
                total++;
                if (out_tag !== 4'(got + 1) || out_data !== ref_pack(va[got], vb[got])) begin
                    bad++;
                    $display("FAIL b2b_order[%0d] got=%h/%h want=%h/%h", got, out_tag, out_data, 4'(got + 1), ref_pack(va[got], vb[got]));
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (got != 4 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count got=%0d trailing_valid=%b want=4/0", got, out_valid);
        end
    endtask

    task automatic test_reset_midflow();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h40000000;
        in_b      = 32'h3F800000;
        in_tag    = 4'hA;
        @(negedge clk);
        in_tag = 4'hB;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midflow_full got_valid=%b got_ready=%b want=1/0", out_valid, in_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midflow_reset got_valid=%b got_ready=%b want=0/1", out_valid, in_ready);
        end
        run_one(32'h60000000, 32'h3F800000, 4'hC);
        total++;
        if (!r_ok || r_lat != 2 || r_tag !== 4'hC || r_data !== 32'h3FC00000) begin
            bad++;
            $display("FAIL midflow_after ok=%b lat=%0d tag=%h data=%h want=1/2/c/3fc00000", r_ok, r_lat, r_tag, r_data);
        end
    endtask

    task automatic test_random();
        logic [31:0]   exp_d [$];
        logic [WT-1:0] exp_t [$];
        logic [31:0]   a;
        logic [31:0]   b;
        logic [31:0]   r;
        logic [31:0]   hd;
        logic [WT-1:0] ht;
        logic [7:0]    ex;
        bit            held;
        int            n;
        int            sent;
        int            got;
        n    = 300;
        sent = 0;
        got  = 0;
        held = 1'b0;
        for (int cyc = 0; cyc < 5000 && got < n; cyc++) begin
            @(negedge clk);
            r = $urandom;
            case ($urandom_range(0, 4))
                0: a = r;
                1: a = r >> $urandom_range(0, 31);
                2: a = r & 32'h0000000F;
                3: a = (r | 32'h40000000) & 32'h7FFFFFFF;
                default: a = r | 32'h7FFFFF80;
            endcase
            case ($urandom_range(0, 3))
                0: ex = 8'($urandom_range(0, 8));
                1: ex = 8'($urandom_range(246, 255));
                default: ex = 8'($urandom_range(0, 255));
            endcase
            r = $urandom;
            b = {r[31], ex, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), r[20:0]};
            in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
            in_a      = a;
            in_b      = b;
            in_tag    = 4'(sent);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== hd || out_tag !== ht) begin
                    bad++;
                    $display("FAIL rand_hold got=%b/%h/%h want=1/%h/%h", out_valid, out_data, out_tag, hd, ht);
                end
            end
            held = out_valid && !out_ready;
            hd   = out_data;
            ht   = out_tag;
            if (out_valid && out_ready) begin
                total++;
                if (exp_d.size() == 0) begin
                    bad++;
                    $display("FAIL rand_spurious got=%h/%h want=none", out_data, out_tag);
                end else begin
                    if (out_data !== exp_d[0] || out_tag !== exp_t[0]) begin
                        bad++;
                        $display("FAIL rand_data[%0d] got=%h/%h want=%h/%h", got, out_data, out_tag, exp_d[0], exp_t[0]);
                    end
                    void'(exp_d.pop_front());
                    void'(exp_t.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_d.push_back(ref_pack(a, b));
                exp_t.push_back(4'(sent));
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL rand_count got=%0d want=%0d", got, n);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
